noc_node_ni: RTL

Parametrised network interface between a processing element and the local (5th) port of a router, replacing the unbuffered PE-to-router hookup. Packs PE payload plus destination into flits, buffers them in an injection FIFO, and sends to the router under credit flow control. Buffers ejected flits in an ejection FIFO and returns credits to the router, so ejection is flow controlled in both directions. Also keeps sticky error flags and traffic counters per node.

---
 rtl/noc_pkg.sv | 36 +++
 rtl/noc_node_ni_if.sv | 45 ++++
 rtl/noc_sync_fifo.sv | 60 ++++++
 rtl/noc_node_ni.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default field widths, flit layout and header helpers
// used by the node network interface and the router.
package noc_pkg;

  localparam int unsigned NOC_CLUSTER_W = 2;
  localparam int unsigned NOC_LOCAL_W   = 2;
  localparam int unsigned NOC_DATA_W    = 16;
  localparam int unsigned NOC_HDR_W     = NOC_CLUSTER_W + NOC_LOCAL_W;
  localparam int unsigned NOC_FLIT_W    = NOC_HDR_W + NOC_DATA_W;

  // Flit layout, MSB first: destination cluster, destination local id, payload
  typedef struct packed {
    logic [NOC_CLUSTER_W-1:0] dst_cluster;
    logic [NOC_LOCAL_W-1:0]   dst_local;
    logic [NOC_DATA_W-1:0]    payload;
  } noc_flit_t;

  function automatic noc_flit_t noc_pack(input logic [NOC_CLUSTER_W-1:0] dst_cluster,
                                         input logic [NOC_LOCAL_W-1:0]   dst_local,
                                         input logic [NOC_DATA_W-1:0]    payload);
    noc_flit_t f;
    f.dst_cluster = dst_cluster;
    f.dst_local   = dst_local;
    f.payload     = payload;
    return f;
  endfunction

  function automatic logic [NOC_HDR_W-1:0] noc_dst(input noc_flit_t f);
    return {f.dst_cluster, f.dst_local};
  endfunction

  function automatic logic [NOC_DATA_W-1:0] noc_payload(input noc_flit_t f);
    return f.payload;
  endfunction

endpackage

// File: rtl/noc_node_ni_if.sv
// PE-side and router-local-port handshake signals of the node network interface.
interface noc_node_ni_if #(
  parameter int unsigned CLUSTER_W = 2,
  parameter int unsigned LOCAL_W   = 2,
  parameter int unsigned DATA_W    = 16
);
  localparam int unsigned FLIT_W = CLUSTER_W + LOCAL_W + DATA_W;

  logic [DATA_W-1:0]    pe_tx_data;
  logic [CLUSTER_W-1:0] pe_tx_dst_cluster;
  logic [LOCAL_W-1:0]   pe_tx_dst_local;
  logic                 pe_tx_valid;
  logic                 pe_tx_ready;
  logic [FLIT_W-1:0]    rtr_tx_flit;
  logic                 rtr_tx_valid;
  logic                 rtr_credit_in;
  logic [FLIT_W-1:0]    rtr_rx_flit;
  logic                 rtr_rx_valid;
  logic                 rtr_credit_out;
  logic [DATA_W-1:0]    pe_rx_data;
  logic                 pe_rx_valid;
  logic                 pe_rx_ready;

  // Network interface side
  modport slave (
    input  pe_tx_data, pe_tx_dst_cluster, pe_tx_dst_local, pe_tx_valid,
    output pe_tx_ready,
    output rtr_tx_flit, rtr_tx_valid,
    input  rtr_credit_in, rtr_rx_flit, rtr_rx_valid,
    output rtr_credit_out,
    output pe_rx_data, pe_rx_valid,
    input  pe_rx_ready
  );

  // PE plus router side
  modport master (
    output pe_tx_data, pe_tx_dst_cluster, pe_tx_dst_local, pe_tx_valid,
    input  pe_tx_ready,
    input  rtr_tx_flit, rtr_tx_valid,
    output rtr_credit_in, rtr_rx_flit, rtr_rx_valid,
    input  rtr_credit_out,
    input  pe_rx_data, pe_rx_valid,
    output pe_rx_ready
  );
endinterface

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted when a pop
// happens in the same cycle.
module noc_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push_c, do_pop_c;

  // Extra wrap bit on the pointers distinguishes full from empty
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop_c  = pop & ~empty_c;
  assign do_push_c = push & (~full_c | do_pop_c);
  assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_c) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/noc_node_ni.sv
// Node network interface: packs PE traffic into flits, injects them under
// router credit flow control, buffers ejected flits and returns credits.
module noc_node_ni
  import noc_pkg::*;
#(
  parameter int unsigned CLUSTER_W   = NOC_CLUSTER_W,
  parameter int unsigned LOCAL_W     = NOC_LOCAL_W,
  parameter int unsigned DATA_W      = NOC_DATA_W,
  parameter int unsigned INJ_DEPTH   = 4,
  parameter int unsigned EJ_DEPTH    = 4,
  parameter int unsigned RTR_CREDITS = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLUSTER_W-1:0] my_cluster,
  input  logic [LOCAL_W-1:0]   my_local,
  noc_node_ni_if.slave         bus,
  output logic                 ovf_err,
  output logic                 misroute_err,
  output logic                 credit_err,
  output logic [CNT_W-1:0]     inj_count,
  output logic [CNT_W-1:0]     ej_count
);
  localparam int unsigned FLIT_W = CLUSTER_W + LOCAL_W + DATA_W;
  localparam int unsigned CRED_W = $clog2(RTR_CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RTR_CREDITS);

  logic              inj_full_c, inj_empty_c, ej_full_c, ej_empty_c;
  logic [FLIT_W-1:0] inj_head_c;
  logic [DATA_W-1:0] ej_head_c;
  logic              inj_push_c, send_c, ej_pop_c;

  logic [CRED_W-1:0] credit_q, credit_d;
  logic              tx_valid_q, tx_valid_d;
  logic [FLIT_W-1:0] tx_flit_q, tx_flit_d;
  logic              credit_out_q, credit_out_d;
  logic              ovf_q, ovf_d;
  logic              misroute_q, misroute_d;
  logic              credit_err_q, credit_err_d;
  logic [CNT_W-1:0]  inj_count_q, inj_count_d;
  logic [CNT_W-1:0]  ej_count_q, ej_count_d;

  // Ready/valid toward the PE come from FIFO state only (plus reset hold-off)
  assign bus.pe_tx_ready = ~inj_full_c & ~rst;
  assign bus.pe_rx_valid = ~ej_empty_c;
  assign bus.pe_rx_data  = ej_head_c;

  assign inj_push_c = bus.pe_tx_valid & bus.pe_tx_ready;
  assign send_c     = ~inj_empty_c & (credit_q != '0);
  assign ej_pop_c   = ~ej_empty_c & bus.pe_rx_ready;

  noc_sync_fifo #(.DEPTH(INJ_DEPTH), .WIDTH(FLIT_W)) u_inj_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inj_push_c),
    .wr_data   ({bus.pe_tx_dst_cluster, bus.pe_tx_dst_local, bus.pe_tx_data}),
    .pop       (send_c),
    .rd_data_c (inj_head_c),
    .full_c    (inj_full_c),
    .empty_c   (inj_empty_c)
  );

  // The header is checked on arrival, so only the payload is buffered
  noc_sync_fifo #(.DEPTH(EJ_DEPTH), .WIDTH(DATA_W)) u_ej_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.rtr_rx_valid),
    .wr_data   (bus.rtr_rx_flit[DATA_W-1:0]),
    .pop       (ej_pop_c),
    .rd_data_c (ej_head_c),
    .full_c    (ej_full_c),
    .empty_c   (ej_empty_c)
  );

  always_comb begin
    credit_d     = credit_q;
    tx_valid_d   = send_c;
    tx_flit_d    = tx_flit_q;
    credit_out_d = ej_pop_c;
    ovf_d        = ovf_q;
    misroute_d   = misroute_q;
    credit_err_d = credit_err_q;
    inj_count_d  = inj_count_q;
    ej_count_d   = ej_count_q;

    if (send_c) begin
      tx_flit_d   = inj_head_c;
      inj_count_d = inj_count_q + CNT_W'(1);
    end
    if (ej_pop_c) begin
      ej_count_d = ej_count_q + CNT_W'(1);
    end

    // Send and credit return in the same cycle cancel out
    case ({send_c, bus.rtr_credit_in})
      2'b10: credit_d = credit_q - CRED_W'(1);
      2'b01: begin
        if (credit_q == CRED_MAX) credit_err_d = 1'b1;
        else                      credit_d     = credit_q + CRED_W'(1);
      end
      default: ;
    endcase

    if (bus.rtr_rx_valid) begin
      if (bus.rtr_rx_flit[FLIT_W-1:DATA_W] != {my_cluster, my_local}) misroute_d = 1'b1;
      if (ej_full_c & ~ej_pop_c) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q     <= CRED_MAX;
      tx_valid_q   <= 1'b0;
      tx_flit_q    <= '0;
      credit_out_q <= 1'b0;
      ovf_q        <= 1'b0;
      misroute_q   <= 1'b0;
      credit_err_q <= 1'b0;
      inj_count_q  <= '0;
      ej_count_q   <= '0;
    end else begin
      credit_q     <= credit_d;
      tx_valid_q   <= tx_valid_d;
      tx_flit_q    <= tx_flit_d;
      credit_out_q <= credit_out_d;
      ovf_q        <= ovf_d;
      misroute_q   <= misroute_d;
      credit_err_q <= credit_err_d;
      inj_count_q  <= inj_count_d;
      ej_count_q   <= ej_count_d;
    end
  end

  assign bus.rtr_tx_valid   = tx_valid_q;
  assign bus.rtr_tx_flit    = tx_flit_q;
  assign bus.rtr_credit_out = credit_out_q;
  assign ovf_err            = ovf_q;
  assign misroute_err       = misroute_q;
  assign credit_err         = credit_err_q;
  assign inj_count          = inj_count_q;
  assign ej_count           = ej_count_q;

endmodule
